dcache_responder: RTL and testbench

- Responder end of the core's data-memory port: services dcache_addr/re/we/din requests, returns dcache_dout, and drives stall to freeze the core pipeline.
- Direct-mapped, one-word-line, write-through, no-write-allocate cache in front of a backing memory.
- Backing memory uses a valid/ready request channel and a valid-only response channel.
- Sits between Riscv151 data ports and the memory arbiter; hit/miss counters exported for CSR/debug readout.

---
 rtl/dcache_responder_if.sv | 34 +++
 rtl/dcache_responder.sv | 155 +++++++++++++++
 tb/tb_dcache_responder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_if.sv
// Backing-memory channel for the data cache responder.
// Valid/ready request, valid-only response.
interface dcache_responder_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_rw,
    output mem_req_addr,
    output mem_req_data,
    output mem_req_mask,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_rw,
    input  mem_req_addr,
    input  mem_req_data,
    input  mem_req_mask,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped write-through no-allocate data cache.
// Freezes the core via stall while memory is busy.
module dcache_responder #(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  dcache_responder_if.master mem,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } state_t;

  state_t state;
  state_t state_nx;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES];

  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             is_wr;
  logic             is_rd;
  logic             idle;
  logic             fill;
  logic             unused_lsb;

  assign idx      = dcache_addr[2 +: IDX_W];
  assign tag      = dcache_addr[31 -: TAG_W];
  assign fill_idx = addr_q[IDX_W-1:0];
  assign fill_tag = addr_q[29 -: TAG_W];
  assign hit      = valid_q[idx] &&
                    (tag_q[idx] == tag);
  assign is_wr    = |dcache_we;
  assign is_rd    = dcache_re && !is_wr;
  assign idle     = (state == IDLE);
  assign fill     = (state == RD_WAIT) &&
                    mem.mem_resp_valid;

  assign unused_lsb = ^dcache_addr[1:0];

  assign mem.mem_req_addr = addr_q;
  assign mem.mem_req_data = wdata_q;
  assign mem.mem_req_mask = mask_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, stall and request strobes
  always_comb begin
    state_nx          = state;
    stall             = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_rw    = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          is_wr:         state_nx = WR_REQ;
          is_rd && !hit: state_nx = RD_REQ;
          default:       state_nx = IDLE;
        endcase
      end
      RD_REQ: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready)
          state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem.mem_resp_valid)
          state_nx = IDLE;
      end
      WR_REQ: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        mem.mem_req_rw    = 1'b1;
        if (mem.mem_req_ready)
          state_nx = IDLE;
      end
    endcase
  end

  // Line storage: write-hit lane merge and refill
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (idle && is_wr && hit) begin
        for (int b = 0; b < 4; b++) begin
          if (dcache_we[b])
            data_q[idx][8*b +: 8] <=
              dcache_din[8*b +: 8];
        end
      end
      if (fill) begin
        data_q[fill_idx] <= mem.mem_resp_data;
        tag_q[fill_idx]  <= fill_tag;
      end
    end
  end

  // Valid bits, request latch, read data, counters
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      dcache_dout <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      if (idle && (is_wr || is_rd)) begin
        addr_q  <= dcache_addr[31:2];
        wdata_q <= dcache_din;
        mask_q  <= dcache_we;
      end
      if (idle && is_rd && hit) begin
        dcache_dout <= data_q[idx];
        hit_count   <= hit_count + 32'd1;
      end
      if (idle && is_rd && !hit)
        miss_count <= miss_count + 32'd1;
      if (fill) begin
        valid_q[fill_idx] <= 1'b1;
        dcache_dout       <= mem.mem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed ops,
// memory model, and dout scoreboard.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dcache_responder_if mif();

  dcache_responder #(.LINES(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .dcache_addr (dcache_addr),
    .dcache_re   (dcache_re),
    .dcache_we   (dcache_we),
    .dcache_din  (dcache_din),
    .dcache_dout (dcache_dout),
    .stall       (stall),
    .mem         (mif),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q [$];

  int          rdy_wait  = 0;
  int          resp_wait = 0;
  logic [31:0] resp_data = '0;
  logic        exp_rw    = 1'b0;
  logic [29:0] exp_addr  = '0;
  logic [3:0]  exp_mask  = '0;
  logic [31:0] exp_data  = '0;
  int          req_cycles = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Scoreboard monitor: a read accepted while
  // unstalled presents data at the first
  // unstalled cycle after acceptance.
  initial begin : monitor
    bit pending;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 1'b0;
      end else begin
        if (pending && !stall) begin
          pending = 1'b0;
          if (exp_q.size() == 0)
            check("sb_underflow", exp_q.size(), 1);
          else
            check("dout", dcache_dout,
                  exp_q.pop_front());
        end
        if (!stall && dcache_re &&
            dcache_we == 4'b0)
          pending = 1'b1;
      end
    end
  end

  initial begin : req_counter
    forever begin
      @(negedge clk);
      if (mif.mem_req_valid) req_cycles++;
    end
  end

  // Backing memory model
  initial begin : mem_model
    mif.mem_req_ready  = 1'b0;
    mif.mem_resp_valid = 1'b0;
    mif.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (mif.mem_req_valid && !reset) begin
        for (int i = 0; i <= rdy_wait; i++) begin
          if (i > 0) @(negedge clk);
          check("req_rw", mif.mem_req_rw, exp_rw);
          check("req_addr", mif.mem_req_addr,
                exp_addr);
          if (exp_rw) begin
            check("req_mask", mif.mem_req_mask,
                  exp_mask);
            check("req_data", mif.mem_req_data,
                  exp_data);
          end
        end
        mif.mem_req_ready = 1'b1;
        @(negedge clk);
        mif.mem_req_ready = 1'b0;
        if (!exp_rw) begin
          repeat (resp_wait) @(negedge clk);
          mif.mem_resp_data  = resp_data;
          mif.mem_resp_valid = 1'b1;
          @(negedge clk);
          mif.mem_resp_valid = 1'b0;
        end
      end
    end
  end

  task automatic op(input logic r,
                    input logic [3:0] w,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    output int sc);
    @(posedge clk); #1;
    dcache_re   = r;
    dcache_we   = w;
    dcache_addr = a;
    dcache_din  = d;
    @(posedge clk); #1;
    sc = 0;
    while (stall && sc < 200) begin
      sc++;
      @(posedge clk); #1;
    end
    if (sc == 200) check("stall_timeout", stall, 0);
    dcache_re = 1'b0;
    dcache_we = 4'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic set_mem(input int rw_, input int rr,
                         input logic [31:0] rd);
    rdy_wait  = rw_;
    resp_wait = rr;
    resp_data = rd;
  endtask

  task automatic set_req(input logic rw,
                         input logic [29:0] a,
                         input logic [3:0] m,
                         input logic [31:0] d);
    exp_rw   = rw;
    exp_addr = a;
    exp_mask = m;
    exp_data = d;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int sc;
    int base;
    reset       = 1'b1;
    dcache_addr = '0;
    dcache_re   = 1'b0;
    dcache_we   = 4'b0;
    dcache_din  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_dout", dcache_dout, 0);
    check("rst_req_valid", mif.mem_req_valid, 0);
    check("rst_req_rw", mif.mem_req_rw, 0);
    check("rst_req_addr", mif.mem_req_addr, 0);
    check("rst_req_data", mif.mem_req_data, 0);
    check("rst_req_mask", mif.mem_req_mask, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    reset = 1'b0;

    // Cold read miss
    set_mem(0, 3, 32'hDEADBEEF);
    set_req(1'b0, 30'h40, 4'h0, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    op(1'b1, 4'h0, 32'h100, 32'h0, sc);
    check("miss_stall", sc, 5);
    check("miss_cnt1", miss_count, 1);
    check("hit_cnt0", hit_count, 0);

    // Read hit
    base = req_cycles;
    exp_q.push_back(32'hDEADBEEF);
    op(1'b1, 4'h0, 32'h100, 32'h0, sc);
    check("hit_stall", sc, 0);
    check("hit_no_req", req_cycles - base, 0);
    check("hit_cnt1", hit_count, 1);

    // Partial write hit, ready late
    set_mem(2, 0, 32'h0);
    set_req(1'b1, 30'h40, 4'b0011, 32'h0000CAFE);
    op(1'b0, 4'b0011, 32'h100, 32'h0000CAFE, sc);
    check("wr_stall", sc, 3);
    exp_q.push_back(32'hDEADCAFE);
    op(1'b1, 4'h0, 32'h100, 32'h0, sc);
    check("merge_stall", sc, 0);
    check("hit_cnt2", hit_count, 2);

    // Write miss does not allocate
    set_mem(0, 0, 32'h0);
    set_req(1'b1, 30'h800, 4'hF, 32'h11112222);
    op(1'b0, 4'hF, 32'h2000, 32'h11112222, sc);
    check("wr_min_stall", sc, 1);
    set_mem(1, 0, 32'h11112222);
    set_req(1'b0, 30'h800, 4'h0, 32'h0);
    exp_q.push_back(32'h11112222);
    op(1'b1, 4'h0, 32'h2000, 32'h0, sc);
    check("noalloc_stall", sc, 3);
    check("miss_cnt2", miss_count, 2);

    // Aliasing on index 0
    set_mem(0, 0, 32'hA0A0A0A0);
    set_req(1'b0, 30'h0, 4'h0, 32'h0);
    exp_q.push_back(32'hA0A0A0A0);
    op(1'b1, 4'h0, 32'h000, 32'h0, sc);
    check("alias0_stall", sc, 2);
    set_mem(0, 0, 32'hDEADCAFE);
    set_req(1'b0, 30'h40, 4'h0, 32'h0);
    exp_q.push_back(32'hDEADCAFE);
    op(1'b1, 4'h0, 32'h100, 32'h0, sc);
    check("alias1_stall", sc, 2);
    set_mem(0, 0, 32'hA0A0A0A0);
    set_req(1'b0, 30'h0, 4'h0, 32'h0);
    exp_q.push_back(32'hA0A0A0A0);
    op(1'b1, 4'h0, 32'h000, 32'h0, sc);
    check("alias2_stall", sc, 2);
    check("miss_cnt5", miss_count, 5);
    check("hit_cnt2b", hit_count, 2);

    // re with we set acts as a write
    set_mem(0, 0, 32'h0);
    set_req(1'b1, 30'h1, 4'b0001, 32'h000000FF);
    op(1'b1, 4'b0001, 32'h004, 32'h000000FF, sc);
    check("rewe_stall", sc, 1);
    check("rewe_dout", dcache_dout, 32'hA0A0A0A0);
    check("rewe_miss", miss_count, 5);
    check("rewe_hit", hit_count, 2);

    // Reset while waiting for the refill
    set_mem(0, 4, 32'hBAD0BAD0);
    set_req(1'b0, 30'h100, 4'h0, 32'h0);
    @(posedge clk); #1;
    dcache_re   = 1'b1;
    dcache_addr = 32'h400;
    dcache_din  = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rdwait_stall", stall, 1);
    reset     = 1'b1;
    dcache_re = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_stall", stall, 0);
    check("abort_dout", dcache_dout, 0);
    check("abort_miss", miss_count, 0);
    check("abort_valid", mif.mem_req_valid, 0);
    repeat (8) @(posedge clk);
    #1;
    check("late_resp_stall", stall, 0);
    check("late_resp_dout", dcache_dout, 0);
    set_mem(0, 0, 32'h55AA55AA);
    exp_q.push_back(32'h55AA55AA);
    op(1'b1, 4'h0, 32'h400, 32'h0, sc);
    check("post_rst_stall", sc, 2);
    check("post_rst_miss", miss_count, 1);
    check("post_rst_hit", hit_count, 0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
